// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter that shares one 8:1 single-bit mux among 8 requesters.
// It holds each grant until the owner releases it, its request drops, or the hold timer expires.
module rr_mux_sel_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  input  logic [7:0] d,
  output logic [2:0] s,
  output logic [7:0] gnt,
  output logic       valid,
  output logic       y
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Timer value on the last permitted grant cycle; unused when HOLD_MAX == 0.
  localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] timer_q, timer_d;
  logic [2:0] s_d;
  logic [7:0] gnt_d;
  logic       valid_d;
  logic       y_d;

  logic       pick_found;
  logic [2:0] pick_idx;
  logic [2:0] cand;
  logic       timeout_hit;
  logic       release_now;

  // Scan the requests starting at ptr so the last grantee has the lowest priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign timeout_hit = (HOLD_MAX != 0) && (timer_q == HOLD_LAST);
  assign release_now = done | ~req[s] | timeout_hit;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    s_d     = s;
    gnt_d   = 8'd0;
    valid_d = 1'b0;
    y_d     = y;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          s_d     = pick_idx;
          gnt_d   = 8'd1 << pick_idx;
          valid_d = 1'b1;
          timer_d = 8'd0;
        end
      end

      GRANT: begin
        // The selected bit is sampled on every grant edge, including the releasing one.
        y_d = d[s];
        if (release_now) begin
          state_d = IDLE;
          ptr_d   = s + 3'd1;
          timer_d = 8'd0;
        end else begin
          gnt_d   = gnt;
          valid_d = 1'b1;
          if (timer_q != 8'hFF) begin
            timer_d = timer_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      timer_q <= 8'd0;
      s       <= 3'd0;
      gnt     <= 8'd0;
      valid   <= 1'b0;
      y       <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      s       <= s_d;
      gnt     <= gnt_d;
      valid   <= valid_d;
      y       <= y_d;
    end
  end

  a_valid_iff_gnt : assert property (@(posedge clk) disable iff (rst) valid == (gnt != 8'd0));
  a_gnt_matches_s : assert property (@(posedge clk) disable iff (rst) valid |-> (gnt == (8'd1 << s)));
  a_valid_state   : assert property (@(posedge clk) disable iff (rst) valid == (state_q == GRANT));

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Randomized and directed stimulus for rr_mux_sel_arbiter, with outputs scoreboarded
// against a cycle-level reference model of the arbitration rules.
module tb_rr_mux_sel_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'd0;
  logic       done = 1'b0;
  logic [7:0] d = 8'd0;
  logic [2:0] s;
  logic [7:0] gnt;
  logic       valid;
  logic       y;

  rr_mux_sel_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .done (done),
    .d    (d),
    .s    (s),
    .gnt  (gnt),
    .valid(valid),
    .y    (y)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         s;
    logic [7:0] gnt;
    logic       valid;
    logic       y;
    int         step;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int step    = 0;

  // Reference model state
  bit   m_busy  = 1'b0;
  int   m_owner = 0;
  int   m_ptr   = 0;
  int   m_age   = 0;
  logic m_y     = 1'b0;

  task automatic check(input string name, input int step_no, input logic [31:0] act,
                       input logic [31:0] req_val);
    n_tests++;
    if (act !== req_val) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, step_no, act, req_val);
    end
  endtask

  // Advance the model by one clock edge using the inputs applied for that edge.
  task automatic model_step(input logic r, input logic [7:0] rq, input logic dn,
                            input logic [7:0] dd);
    exp_t e;
    if (r) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_y = 1'b0;
    end else if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        int who;
        who = (m_ptr + k) % 8;
        if (rq[who]) begin
          m_busy  = 1;
          m_owner = who;
          m_age   = 0;
          break;
        end
      end
    end else begin
      m_y = dd[m_owner];
      if (dn || !rq[m_owner] || (HOLD != 0 && m_age == HOLD - 1)) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % 8;
        m_age  = 0;
      end else if (m_age < 255) begin
        m_age++;
      end
    end
    e.s     = m_owner;
    e.gnt   = m_busy ? 8'(1 << m_owner) : 8'd0;
    e.valid = m_busy;
    e.y     = m_y;
    e.step  = step;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic r, input logic [7:0] rq, input logic dn, input logic [7:0] dd);
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = dn;
    d    = dd;
    step++;
    model_step(r, rq, dn, dd);
  endtask

  // Monitor: every DUT output update after an issued edge is compared to the model.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("s",     e.step, 32'(s),     32'(e.s));
      check("gnt",   e.step, 32'(gnt),   32'(e.gnt));
      check("valid", e.step, 32'(valid), 32'(e.valid));
      check("y",     e.step, 32'(y),     32'(e.y));
    end
  end

  initial begin
    logic [7:0] cur_req;

    // Reset held with every requester active; first grant must go to 0.
    cycle(1, 8'hFF, 0, 8'h00);
    cycle(1, 8'hFF, 0, 8'h00);

    // Fairness sweep: done on each grant's second cycle, order 0..7 then 0.
    for (int g = 0; g < 9; g++) begin
      cycle(0, 8'hFF, 0, 8'hA5);
      cycle(0, 8'hFF, 0, 8'h5A);
      cycle(0, 8'hFF, 1, 8'hC3);
    end

    // Single requester with data, then done release.
    cycle(1, 8'h00, 0, 8'h00);
    cycle(0, 8'h20, 0, 8'h20);
    cycle(0, 8'h20, 0, 8'h20);
    cycle(0, 8'h20, 1, 8'h20);
    cycle(0, 8'h00, 0, 8'h00);

    // Timeout: requester 3 held with no done.
    for (int i = 0; i < 12; i++) cycle(0, 8'h08, 0, 8'h08);

    // Pointer wrap: release 7, then 0 must win over 6.
    cycle(0, 8'h00, 0, 8'h00);
    cycle(0, 8'h80, 0, 8'h80);
    cycle(0, 8'h80, 1, 8'h80);
    cycle(0, 8'h41, 0, 8'h41);
    cycle(0, 8'h41, 1, 8'h41);
    cycle(0, 8'h00, 0, 8'h00);

    // Reset mid-grant of requester 4, then 4 wins from ptr=0.
    cycle(0, 8'h10, 0, 8'h10);
    cycle(0, 8'h10, 0, 8'h10);
    cycle(1, 8'h10, 0, 8'h10);
    cycle(0, 8'h90, 0, 8'h90);
    cycle(0, 8'h90, 0, 8'h90);

    // Randomized traffic with occasional request changes, done pulses and resets.
    cur_req = 8'hFF;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) begin
        cur_req = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      end
      cycle(($urandom_range(149) == 0), cur_req, ($urandom_range(4) == 0), 8'($urandom));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", step, 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
